// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: producer, scoreboard and register-file write-port signals of the writeback arbiter
interface wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  issue_en;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  pipe_stall;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, issue_en, issue_addr, rs1_addr, rs2_addr,
    input  b_ready, rs1_busy, rs2_busy, pipe_stall, write_enable, write_addr, write_data
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, issue_en, issue_addr, rs1_addr, rs2_addr,
    output b_ready, rs1_busy, rs2_busy, pipe_stall, write_enable, write_addr, write_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter with a busy scoreboard for long-latency results
module wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = $clog2(STARVE_LIMIT + 1);
  logic                  acc_a, acc_b, we_d, we_q, stall_d, stall_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic [DEPTH-1:0]      busy_d, busy_q;
  logic [CW-1:0]         cnt_d, cnt_q;
  assign acc_a        = bus.a_valid;
  assign acc_b        = bus.b_valid && !bus.a_valid;
  assign bus.b_ready  = !bus.a_valid;
  assign bus.rs1_busy = busy_q[bus.rs1_addr];
  assign bus.rs2_busy = busy_q[bus.rs2_addr];
  assign bus.pipe_stall   = stall_q;
  assign bus.write_enable = we_q;
  assign bus.write_addr   = addr_q;
  assign bus.write_data   = data_q;
  // next write-port contents: A has fixed priority, x0 writes are accepted but swallowed
  always_comb begin
    we_d   = acc_a ? bus.a_addr != '0 : acc_b && bus.b_addr != '0;
    addr_d = acc_a ? bus.a_addr : acc_b ? bus.b_addr : addr_q;
    data_d = acc_a ? bus.a_data : acc_b ? bus.b_data : data_q;
  end
  // scoreboard: clear on B acceptance first so a same-cycle issue wins; x0 is never busy
  always_comb begin
    busy_d = busy_q;
    if (acc_b) busy_d[bus.b_addr] = 1'b0;
    if (bus.issue_en) busy_d[bus.issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // starvation: count consecutive refused B cycles, saturating; stall once the limit is reached
  always_comb begin
    cnt_d   = !(bus.b_valid && bus.a_valid) ? '0 : cnt_q == CW'(STARVE_LIMIT) ? cnt_q : cnt_q + 1'b1;
    stall_d = cnt_d == CW'(STARVE_LIMIT);
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench with directed scenarios and randomized traffic against a reference model
`timescale 1ns/1ps
module tb_wb_arbiter;
  localparam int LIMIT = 4;
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int refused = 0;
  bit mbusy [32];
  bit mstall = 1'b0;
  wr_t q [$];
  wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
    bus.issue_en = 0; bus.issue_addr = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
  endtask
  // reference model: a write request accepted at an edge must be visible right after that edge
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      foreach (mbusy[i]) mbusy[i] = 0;
      refused = 0;
      mstall = 0;
    end else begin
      if (bus.a_valid && bus.a_addr != 0) q.push_back('{bus.a_addr, bus.a_data, cyc});
      else if (bus.b_valid && !bus.a_valid && bus.b_addr != 0) q.push_back('{bus.b_addr, bus.b_data, cyc});
      if (bus.b_valid && !bus.a_valid) mbusy[bus.b_addr] = 0;
      if (bus.issue_en && bus.issue_addr != 0) mbusy[bus.issue_addr] = 1;
      refused = (bus.b_valid && bus.a_valid) ? refused + 1 : 0;
      mstall = refused >= LIMIT;
    end
  end
  // monitor: compares every cycle's write port, handshake and busy flags with the model
  initial forever begin
    @(negedge clk);
    begin
      bit exp_we;
      wr_t e;
      exp_we = q.size() != 0 && q[0].cyc == cyc;
      chk("write_enable", bus.write_enable, exp_we);
      if (exp_we) begin
        e = q.pop_front();
        chk("write_addr", bus.write_addr, e.addr);
        chk("write_data", bus.write_data, e.data);
      end
      chk("b_ready", bus.b_ready, !bus.a_valid);
      chk("rs1_busy", bus.rs1_busy, mbusy[bus.rs1_addr]);
      chk("rs2_busy", bus.rs2_busy, mbusy[bus.rs2_addr]);
      chk("pipe_stall", bus.pipe_stall, mstall);
    end
  end
  initial begin
    idle();
    tick(); tick();
    reset = 0;
    chk("rst_we", bus.write_enable, 0);
    chk("rst_addr", bus.write_addr, 0);
    chk("rst_data", bus.write_data, 0);
    chk("rst_rs1", bus.rs1_busy, 0);
    chk("rst_bready", bus.b_ready, 1);
    chk("rst_stall", bus.pipe_stall, 0);
    tick();
    bus.a_valid = 1; bus.a_addr = 5; bus.a_data = 32'hDEADBEEF;
    tick();
    bus.a_valid = 0;
    chk("a_we", bus.write_enable, 1);
    chk("a_addr", bus.write_addr, 5);
    chk("a_data", bus.write_data, 32'hDEADBEEF);
    tick();
    chk("a_we_off", bus.write_enable, 0);
    bus.a_valid = 1; bus.a_addr = 3; bus.a_data = 32'h11;
    bus.b_valid = 1; bus.b_addr = 7; bus.b_data = 32'h22;
    #1 chk("col_bready0", bus.b_ready, 0);
    tick();
    chk("col_a_addr", bus.write_addr, 3);
    bus.a_valid = 0;
    #1 chk("col_bready1", bus.b_ready, 1);
    tick();
    bus.b_valid = 0;
    chk("col_b_addr", bus.write_addr, 7);
    chk("col_b_data", bus.write_data, 32'h22);
    bus.issue_en = 1; bus.issue_addr = 9; bus.rs1_addr = 9;
    #1 chk("sb_nobypass", bus.rs1_busy, 0);
    tick();
    bus.issue_en = 0;
    chk("sb_set", bus.rs1_busy, 1);
    bus.b_valid = 1; bus.b_addr = 9; bus.b_data = 32'h99;
    tick();
    bus.b_valid = 0;
    chk("sb_clear", bus.rs1_busy, 0);
    bus.issue_en = 1;
    tick();
    bus.b_valid = 1;
    tick();
    bus.b_valid = 0; bus.issue_en = 0;
    chk("sb_set_wins", bus.rs1_busy, 1);
    bus.b_valid = 1;
    tick();
    bus.b_valid = 0;
    bus.issue_en = 1; bus.issue_addr = 0;
    tick();
    bus.issue_en = 0; bus.rs1_addr = 0;
    #1 chk("x0_busy", bus.rs1_busy, 0);
    bus.a_valid = 1; bus.a_addr = 0; bus.a_data = 32'hFFFFFFFF;
    tick();
    bus.a_valid = 0;
    chk("x0_we", bus.write_enable, 0);
    bus.a_valid = 1; bus.a_addr = 1; bus.a_data = 32'h1;
    bus.b_valid = 1; bus.b_addr = 12; bus.b_data = 32'hC0FFEE;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("starve_stall", bus.pipe_stall, i == 4);
    end
    bus.a_valid = 0;
    tick();
    bus.b_valid = 0;
    chk("drain_stall", bus.pipe_stall, 0);
    chk("drain_addr", bus.write_addr, 12);
    bus.issue_en = 1; bus.issue_addr = 20;
    tick();
    bus.issue_en = 0;
    bus.a_valid = 1; bus.b_valid = 1; bus.b_addr = 20;
    tick();
    reset = 1;
    tick();
    reset = 0;
    idle();
    chk("rstmid_we", bus.write_enable, 0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      #0.2 chk("rstmid_busy", bus.rs1_busy, 0);
    end
    tick();
    for (int n = 0; n < 3000; n++) begin
      if (reset) begin
        reset = 0;
        bus.b_valid = 0;
      end
      if (!bus.b_valid || !bus.a_valid) begin
        bus.b_valid = $urandom_range(0, 2) == 0;
        bus.b_addr = 5'($urandom);
        bus.b_data = $urandom;
      end
      bus.a_valid = bus.pipe_stall ? 1'b0 : $urandom_range(0, 3) != 0;
      bus.a_addr = 5'($urandom);
      bus.a_data = $urandom;
      bus.issue_en = $urandom_range(0, 2) == 0;
      bus.issue_addr = 5'($urandom);
      bus.rs1_addr = 5'($urandom);
      bus.rs2_addr = 5'($urandom);
      reset = $urandom_range(0, 399) == 0;
      tick();
    end
    reset = 0;
    idle();
    tick(); tick();
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Drives the register file's single write port and arbitrates between two result producers.
  - The in-order pipeline writeback (port A) has no backpressure.
  - A long-latency unit (port B: multiply/divide/load-miss) uses a valid/ready handshake.
- Holds a 32-entry busy scoreboard of destinations owned by port B.
- Exposes busy flags for two source registers so decode can stall on RAW hazards.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width; scoreboard depth is 2**ADDR_WIDTH
- STARVE_LIMIT, 4, consecutive cycles port B may be refused before pipe_stall asserts

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- a_valid  input  1  pipeline writeback request
- a_addr  input  ADDR_WIDTH  pipeline destination register
- a_data  input  DATA_WIDTH  pipeline result
- b_valid  input  1  long-latency result valid
- b_ready  output  1  long-latency result accepted this cycle
- b_addr  input  ADDR_WIDTH  long-latency destination register
- b_data  input  DATA_WIDTH  long-latency result
- issue_en  input  1  an op dispatched to the long-latency unit this cycle
- issue_addr  input  ADDR_WIDTH  destination of the dispatched op
- rs1_addr  input  ADDR_WIDTH  decode source 1 query
- rs2_addr  input  ADDR_WIDTH  decode source 2 query
- rs1_busy  output  1  rs1 pending in scoreboard
- rs2_busy  output  1  rs2 pending in scoreboard
- pipe_stall  output  1  freeze pipeline so port B can drain
- write_enable  output  1  register file write enable
- write_addr  output  ADDR_WIDTH  register file write address
- write_data  output  DATA_WIDTH  register file write data

Behaviour:
- Reset (synchronous, highest priority) sets to zero:
  - write_enable, write_addr, write_data
  - all scoreboard bits
  - the starvation counter
  - pipe_stall
- Write-port outputs are registered. A request accepted in cycle N appears on write_enable/addr/data in cycle N+1 for exactly one cycle.
- Arbitration: port A has fixed priority.
  - b_ready = !a_valid (combinational). When a_valid=0, b_ready is 1 whether or not b_valid is set.
  - B handshake completes only when b_valid && b_ready.
  - With A and B both valid, A is written and B is held. B must keep addr/data stable until accepted.
- Register x0:
  - A or B request with addr 0 is accepted (handshake completes) but write_enable stays 0 next cycle.
  - issue_addr=0 never sets a busy bit.
  - rs*_busy for address 0 is always 0.
- Scoreboard:
  - issue_en with issue_addr!=0 sets busy[issue_addr] at the next edge.
  - An accepted B transfer clears busy[b_addr] at the next edge.
  - Set and clear of the same address in the same cycle: set wins (a new op is in flight).
- Busy queries are combinational reads of the registered scoreboard; there is no same-cycle bypass of issue_en.
- An A write to a busy register is performed and leaves the busy bit unchanged (B result will overwrite later; WAW ordering is the issuer's responsibility).
- Starvation counter:
  - Increments each cycle b_valid && !b_ready, saturating at STARVE_LIMIT.
  - Clears on B acceptance or when b_valid=0.
  - pipe_stall is registered. It is 1 whenever counter==STARVE_LIMIT and stays 1 until B is accepted.
  - The pipeline guarantees a_valid=0 one cycle after seeing pipe_stall, so B is accepted then.
- Reset mid-operation:
  - A pending B request is dropped and busy bits are lost.
  - b_ready follows the a_valid rule on the first cycle after reset.

Test Plan:
1. Reset, then idle → write_enable=0, write_addr=0, write_data=0, rs1_busy=0, b_ready=1, pipe_stall=0.
2. A-only write: a_valid=1, a_addr=5, a_data=0xDEADBEEF in cycle N → in cycle N+1 write_enable=1, write_addr=5, write_data=0xDEADBEEF; in cycle N+2 write_enable=0.
3. Collision: a_valid=1 (addr 3, 0x11) with b_valid=1 (addr 7, 0x22) → b_ready=0 and reg3 written. Next cycle a_valid=0 → b_ready=1, and reg7 write of 0x22 appears one cycle later.
4. Scoreboard:
   - issue_en with issue_addr=9, then rs1_addr=9 → rs1_busy=1 from the following cycle.
   - B accept to addr 9 → rs1_busy=0 the cycle after.
   - Same-cycle issue_addr=9 and B accept to 9 → busy stays 1.
5. x0 handling: issue_addr=0, then a_addr=0 with data 0xFFFFFFFF → rs1_busy(0)=0 and write_enable never asserts.
6. Starvation: hold a_valid=1 and b_valid=1 for 4 cycles → pipe_stall=1 after the 4th. Then drop a_valid → B accepted, pipe_stall=0 the following cycle. Also assert reset while B is pending → all busy bits 0 and write_enable=0 next cycle.
